// File: rtl/instr_controller_if.sv
// instr_controller_if
//
// Bundles the start/instruction inputs and all datapath control outputs of
// instr_controller into one interface.
//
// Signals:
//   s            start request, sampled only while the controller is idle
//   ins[15:0]    instruction word, captured when s is accepted
//   w            idle/waiting flag
//   readnum      register-file read index
//   writenum     register-file write index
//   write        register-file write enable
//   loada/b/c/s  datapath load enables (A, B, C, status)
//   asel         1 forces the A operand to zero
//   bsel         0 selects the shifted B operand
//   vsel         writeback select (1 = datapath_in, 0 = C)
//   shift        shifter control
//   ALUop        ALU operation
//   datapath_in  sign-extended immediate from the instruction register
//   illegal      illegal-opcode flag
//
// Modports:
//   master  drives s/ins and observes the controls (instruction source, testbench)
//   slave   the controller itself
interface instr_controller_if;
  logic        s;
  logic [15:0] ins;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;
  logic        illegal;

  modport master (
    output s, ins,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, datapath_in, illegal
  );

  modport slave (
    input  s, ins,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, datapath_in, illegal
  );
endinterface

// File: rtl/instr_controller.sv
// instr_controller
//
// Multi-cycle control FSM for a small 16-bit datapath. An instruction is
// captured into the internal instruction register (IR) when s is seen while
// idle, then stepped through read / compute / writeback states. All outputs are
// Moore: they depend only on the current state and IR.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset; wins over s on the same edge
//   bus    instr_controller_if.slave -- s/ins in, datapath controls out
//
// Supported instructions ({opcode, op}):
//   110/10 MOV Rn,#imm8   110/00 MOV Rd,Rm{sh}
//   101/00 ADD  101/01 CMP  101/10 AND  101/11 MVN
//   anything else is illegal.
//
// Configuration:
//   CTRL_ILLEGAL_TRAP_EN  when defined, an illegal instruction parks the FSM in
//                         HALT with a sticky illegal flag until reset. When
//                         undefined, illegal instructions fall back to WAIT and
//                         illegal is tied to 0.
module instr_controller (
  input logic               clk,
  input logic               reset,
  instr_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StCompute,
    StWriteReg,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // IR fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic [7:0] imm8;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign imm8   = ir_q[7:0];

  // Instruction class decode
  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;
  logic is_alu_ab, is_legal;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_add     = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_and     = (opcode == 3'b101) && (op == 2'b10);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  // Two-operand ALU ops need A loaded before B
  assign is_alu_ab  = is_add | is_cmp | is_and;
  assign is_legal   = is_mov_imm | is_mov_reg | is_alu_ab | is_mvn;

  // Sticky illegal flag, only present when trapping is enabled
  logic illegal_int;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d   = illegal_q | ((state_q == StDecode) && !is_legal);
  assign illegal_int = illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`else
  assign illegal_int = 1'b0;
`endif

  // State and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StWait: begin
        if (bus.s) begin
          ir_d    = bus.ins;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWriteImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu_ab) begin
          state_d = StGetA;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StWait;
`endif
        end
      end
      StWriteImm: state_d = StWait;
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StCompute;
      // CMP only updates status, so it skips the writeback
      StCompute:  state_d = is_cmp ? StWait : StWriteReg;
      StWriteReg: state_d = StWait;
      // Only reset leaves HALT
      StHalt:     state_d = StHalt;
      default:    state_d = StWait;
    endcase
  end

  // Moore outputs
  logic       w_o;
  logic [2:0] readnum_o, writenum_o;
  logic       write_o, loada_o, loadb_o, loadc_o, loads_o;
  logic       asel_o, bsel_o, vsel_o;
  logic [1:0] aluop_o;

  always_comb begin
    w_o        = 1'b0;
    readnum_o  = 3'd0;
    writenum_o = 3'd0;
    write_o    = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    vsel_o     = 1'b0;
    aluop_o    = 2'b00;
    unique case (state_q)
      StWait: w_o = 1'b1;
      StWriteImm: begin
        writenum_o = rn;
        vsel_o     = 1'b1;
        write_o    = 1'b1;
      end
      StGetA: begin
        readnum_o = rn;
        loada_o   = 1'b1;
      end
      StGetB: begin
        readnum_o = rm;
        loadb_o   = 1'b1;
      end
      StCompute: begin
        // Single-operand ops pass B through the ALU with A forced to zero
        asel_o  = is_mov_reg | is_mvn;
        aluop_o = is_mov_reg ? 2'b00 : op;
        loadc_o = !is_cmp;
        loads_o = is_cmp;
      end
      StWriteReg: begin
        writenum_o = rd;
        write_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w           = w_o;
  assign bus.readnum     = readnum_o;
  assign bus.writenum    = writenum_o;
  assign bus.write       = write_o;
  assign bus.loada       = loada_o;
  assign bus.loadb       = loadb_o;
  assign bus.loadc       = loadc_o;
  assign bus.loads       = loads_o;
  assign bus.asel        = asel_o;
  assign bus.bsel        = bsel_o;
  assign bus.vsel        = vsel_o;
  assign bus.ALUop       = aluop_o;
  assign bus.shift       = sh;
  assign bus.datapath_in = {{8{imm8[7]}}, imm8};
  assign bus.illegal     = illegal_int;

endmodule
